// File: rtl/mode_switcher_sync_if.sv
// Data-stream bundle between the acquisition/test engines and the mode switcher.
// master = engine side (drives source words), slave = switcher (drives FIFO/parallel words).
interface mode_switcher_sync_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] AcqData;
  logic                  AcqData_en;
  logic [DATA_WIDTH-1:0] SweepAcqData;
  logic                  SweepAcqData_en;
  logic [DATA_WIDTH-1:0] SCTestData;
  logic                  SCTestData_en;
  logic [DATA_WIDTH-1:0] UsbFifoData;
  logic                  UsbFifoData_en;
  logic [DATA_WIDTH-1:0] ParallelData;
  logic                  ParallelData_en;

  modport master (
    output AcqData, AcqData_en, SweepAcqData, SweepAcqData_en, SCTestData, SCTestData_en,
    input  UsbFifoData, UsbFifoData_en, ParallelData, ParallelData_en
  );
  modport slave (
    input  AcqData, AcqData_en, SweepAcqData, SweepAcqData_en, SCTestData, SCTestData_en,
    output UsbFifoData, UsbFifoData_en, ParallelData, ParallelData_en
  );
endinterface

// File: rtl/mode_switcher_sync.sv
// Registered ACQ / S-curve / sweep-ACQ mode mux with a drain-reset-settle handover FSM.
// Latency: 1 cycle in RUN; no backpressure, data is forwarded or dropped by mode.
module mode_switcher_sync #(
  parameter int DAC_WIDTH     = 10,
  parameter int DAC_NUM       = 3,
  parameter int DAC_SEL_WIDTH = 2,
  parameter int MASK_WIDTH    = 192,
  parameter int CTEST_WIDTH   = 64,
  parameter int DATA_WIDTH    = 16,
  parameter int QUIET_CYCLES  = 8,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                         Clk,
  input  logic                         reset_n,
  input  logic [1:0]                   ModeSelect,
  input  logic [DAC_NUM*DAC_WIDTH-1:0] UsbDac,
  input  logic [DAC_WIDTH-1:0]         SCTestDac,
  input  logic [DAC_WIDTH-1:0]         SweepAcqDac,
  input  logic [DAC_SEL_WIDTH-1:0]     SweepAcqDacSelect,
  input  logic [MASK_WIDTH-1:0]        UsbChannelMask,
  input  logic [MASK_WIDTH-1:0]        SCTestChannelMask,
  input  logic [CTEST_WIDTH-1:0]       UsbCTestChannel,
  input  logic [CTEST_WIDTH-1:0]       SCTestCTestChannel,
  input  logic                         UsbSCParameterLoad,
  input  logic                         SCTestSCParameterLoad,
  input  logic                         SweepAcqSCParameterLoad,
  input  logic                         UsbSCOrReadreg,
  input  logic                         UsbAcqStartStop,
  input  logic                         UsbSweepTestStartStop,
  input  logic                         SweepTestUsbStartStop,
  input  logic                         SweepAcqAcqStartStop,
  input  logic                         SCTestDone,
  input  logic                         SweepAcqDone,
  input  logic                         SweepAcqSingleDacDone,
  mode_switcher_sync_if.slave          dataIf,
  output logic [DAC_NUM*DAC_WIDTH-1:0] OutDac,
  output logic [MASK_WIDTH-1:0]        OutChannelMask,
  output logic [CTEST_WIDTH-1:0]       OutCTestChannel,
  output logic                         OutSCParameterLoad,
  output logic                         OutSCOrReadreg,
  output logic                         OutSCTestStartStop,
  output logic                         OutSweepAcqStartStop,
  output logic                         OutUsbStartStop,
  output logic                         AcqStartStop,
  output logic                         SweepTestDone,
  output logic                         OutForceReset,
  output logic [1:0]                   ActiveMode,
  output logic                         ModeSwitchBusy,
  output logic                         ModeSwitchDone,
  output logic                         ModeSwitchTimeout
);
  localparam logic [1:0] MODE_ACQ = 2'b00, MODE_SCURVE = 2'b01, MODE_SWEEP = 2'b10;
  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} stateT;

  stateT state, stateNext;
  logic [1:0] PendingMode, activeNext, pendingNext, selMode;
  logic [QW-1:0] QuietCnt, quietNext;
  logic [DW-1:0] DrainCnt, drainNext;
  logic [SW-1:0] SettleCnt, settleNext;
  logic doneNext, timeoutNext, forcePulse, oldEn, holdStarts, holdData;

  logic [DAC_NUM*DAC_WIDTH-1:0] rDac;
  logic [MASK_WIDTH-1:0]        rMask;
  logic [CTEST_WIDTH-1:0]       rCTest;
  logic [DATA_WIDTH-1:0]        rFifo, rPar;
  logic rLoad, rReadreg, rScStart, rSwStart, rUsbStart, rAcqStart, rTestDone, rForce;
  logic rFifoEn, rParEn;

  assign selMode = (ModeSelect == 2'b11) ? MODE_ACQ : ModeSelect;

  always_comb begin
    case (ActiveMode)
      MODE_SCURVE: oldEn = dataIf.SCTestData_en;
      MODE_SWEEP:  oldEn = dataIf.SweepAcqData_en | dataIf.AcqData_en;
      default:     oldEn = dataIf.AcqData_en;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      ActiveMode  <= MODE_ACQ;
      PendingMode <= MODE_ACQ;
      QuietCnt    <= '0;
      DrainCnt    <= '0;
      SettleCnt   <= '0;
    end else begin
      state       <= stateNext;
      ActiveMode  <= activeNext;
      PendingMode <= pendingNext;
      QuietCnt    <= quietNext;
      DrainCnt    <= drainNext;
      SettleCnt   <= settleNext;
    end
  end

  always_comb begin
    stateNext   = state;
    activeNext  = ActiveMode;
    pendingNext = PendingMode;
    quietNext   = QuietCnt;
    drainNext   = DrainCnt;
    settleNext  = SettleCnt;
    doneNext    = 1'b0;
    timeoutNext = 1'b0;
    forcePulse  = 1'b0;
    case (state)
      ST_RUN: begin
        quietNext  = '0;
        drainNext  = '0;
        settleNext = '0;
        if (selMode != ActiveMode) begin
          stateNext   = ST_DRAIN;
          pendingNext = selMode;
        end
      end
      ST_DRAIN: begin
        if (selMode == ActiveMode) begin
          stateNext = ST_RUN;
        end else begin
          pendingNext = selMode;
          if (QuietCnt == QW'(QUIET_CYCLES) || DrainCnt == DW'(DRAIN_TIMEOUT - 1)) begin
            stateNext   = ST_SETTLE;
            activeNext  = PendingMode;
            forcePulse  = 1'b1;
            timeoutNext = (QuietCnt != QW'(QUIET_CYCLES));
          end else begin
            drainNext = DrainCnt + 1'b1;
            if (oldEn) quietNext = '0;
            else if (QuietCnt != QW'(QUIET_CYCLES)) quietNext = QuietCnt + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (SettleCnt == SW'(SETTLE_CYCLES - 1)) begin
          stateNext  = ST_RUN;
          doneNext   = 1'b1;
          settleNext = '0;
        end else begin
          settleNext = SettleCnt + 1'b1;
        end
      end
      default: stateNext = ST_RUN;
    endcase
  end

  // Routing follows the mode that will be active after this edge, so SETTLE already sees the new mode.
  always_comb begin
    rDac      = UsbDac;
    rMask     = UsbChannelMask;
    rCTest    = UsbCTestChannel;
    rLoad     = UsbSCParameterLoad;
    rReadreg  = UsbSCOrReadreg;
    rScStart  = 1'b0;
    rSwStart  = 1'b0;
    rUsbStart = UsbAcqStartStop;
    rAcqStart = UsbAcqStartStop;
    rTestDone = 1'b0;
    rForce    = 1'b0;
    rFifo     = dataIf.AcqData;
    rFifoEn   = dataIf.AcqData_en;
    rPar      = '0;
    rParEn    = 1'b0;
    case (activeNext)
      MODE_SCURVE: begin
        rDac      = {DAC_NUM{SCTestDac}};
        rMask     = SCTestChannelMask;
        rCTest    = SCTestCTestChannel;
        rLoad     = SCTestSCParameterLoad;
        rReadreg  = 1'b0;
        rScStart  = UsbSweepTestStartStop;
        rTestDone = SCTestDone;
        rUsbStart = SweepTestUsbStartStop;
        rAcqStart = 1'b0;
        rFifo     = dataIf.SCTestData;
        rFifoEn   = dataIf.SCTestData_en;
      end
      MODE_SWEEP: begin
        for (int k = 0; k < DAC_NUM; k++) begin
          if (int'(SweepAcqDacSelect) == k) rDac[k*DAC_WIDTH +: DAC_WIDTH] = SweepAcqDac;
        end
        rLoad     = SweepAcqSCParameterLoad;
        rReadreg  = 1'b0;
        rSwStart  = UsbSweepTestStartStop;
        rTestDone = SweepAcqDone;
        rUsbStart = SweepTestUsbStartStop;
        rAcqStart = SweepAcqAcqStartStop;
        rForce    = SweepAcqSingleDacDone;
        rFifo     = dataIf.SweepAcqData;
        rFifoEn   = dataIf.SweepAcqData_en;
        rPar      = dataIf.AcqData;
        rParEn    = dataIf.AcqData_en;
      end
      default: ;
    endcase
  end

  assign holdStarts = (stateNext != ST_RUN);
  assign holdData   = (stateNext == ST_SETTLE);

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      OutDac                 <= '0;
      OutChannelMask         <= '0;
      OutCTestChannel        <= '0;
      OutSCParameterLoad     <= 1'b0;
      OutSCOrReadreg         <= 1'b0;
      OutSCTestStartStop     <= 1'b0;
      OutSweepAcqStartStop   <= 1'b0;
      OutUsbStartStop        <= 1'b0;
      AcqStartStop           <= 1'b0;
      SweepTestDone          <= 1'b0;
      OutForceReset          <= 1'b0;
      ModeSwitchBusy         <= 1'b0;
      ModeSwitchDone         <= 1'b0;
      ModeSwitchTimeout      <= 1'b0;
      dataIf.UsbFifoData     <= '0;
      dataIf.UsbFifoData_en  <= 1'b0;
      dataIf.ParallelData    <= '0;
      dataIf.ParallelData_en <= 1'b0;
    end else begin
      OutDac                 <= rDac;
      OutChannelMask         <= rMask;
      OutCTestChannel        <= rCTest;
      OutSCOrReadreg         <= rReadreg;
      OutSCParameterLoad     <= rLoad & ~holdStarts;
      OutSCTestStartStop     <= rScStart & ~holdStarts;
      OutSweepAcqStartStop   <= rSwStart & ~holdStarts;
      OutUsbStartStop        <= rUsbStart & ~holdStarts;
      AcqStartStop           <= rAcqStart & ~holdStarts;
      SweepTestDone          <= rTestDone & ~holdStarts;
      OutForceReset          <= forcePulse | (rForce & ~holdStarts);
      ModeSwitchBusy         <= holdStarts;
      ModeSwitchDone         <= doneNext;
      ModeSwitchTimeout      <= timeoutNext;
      dataIf.UsbFifoData     <= holdData ? '0 : rFifo;
      dataIf.UsbFifoData_en  <= rFifoEn & ~holdData;
      dataIf.ParallelData    <= holdData ? '0 : rPar;
      dataIf.ParallelData_en <= rParEn & ~holdData;
    end
  end
endmodule

// File: tb/tb_mode_switcher_sync.sv
// Directed bench for mode_switcher_sync: routing vector table plus hand-built switch sequences.
module tb_mode_switcher_sync;
  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ModeSelect;
  logic [29:0] UsbDac;
  logic [9:0]  SCTestDac, SweepAcqDac;
  logic [1:0]  SweepAcqDacSelect;
  logic [191:0] UsbChannelMask, SCTestChannelMask;
  logic [63:0] UsbCTestChannel, SCTestCTestChannel;
  logic UsbSCParameterLoad, SCTestSCParameterLoad, SweepAcqSCParameterLoad, UsbSCOrReadreg;
  logic UsbAcqStartStop, UsbSweepTestStartStop, SweepTestUsbStartStop, SweepAcqAcqStartStop;
  logic SCTestDone, SweepAcqDone, SweepAcqSingleDacDone;
  logic [29:0] OutDac;
  logic [191:0] OutChannelMask;
  logic [63:0] OutCTestChannel;
  logic OutSCParameterLoad, OutSCOrReadreg, OutSCTestStartStop, OutSweepAcqStartStop;
  logic OutUsbStartStop, AcqStartStop, SweepTestDone, OutForceReset;
  logic [1:0] ActiveMode;
  logic ModeSwitchBusy, ModeSwitchDone, ModeSwitchTimeout;

  mode_switcher_sync_if #(.DATA_WIDTH(16)) dataIf();

  always #5 Clk = ~Clk;

  mode_switcher_sync dut (
    .Clk(Clk), .reset_n(reset_n), .ModeSelect(ModeSelect),
    .UsbDac(UsbDac), .SCTestDac(SCTestDac), .SweepAcqDac(SweepAcqDac),
    .SweepAcqDacSelect(SweepAcqDacSelect),
    .UsbChannelMask(UsbChannelMask), .SCTestChannelMask(SCTestChannelMask),
    .UsbCTestChannel(UsbCTestChannel), .SCTestCTestChannel(SCTestCTestChannel),
    .UsbSCParameterLoad(UsbSCParameterLoad), .SCTestSCParameterLoad(SCTestSCParameterLoad),
    .SweepAcqSCParameterLoad(SweepAcqSCParameterLoad), .UsbSCOrReadreg(UsbSCOrReadreg),
    .UsbAcqStartStop(UsbAcqStartStop), .UsbSweepTestStartStop(UsbSweepTestStartStop),
    .SweepTestUsbStartStop(SweepTestUsbStartStop), .SweepAcqAcqStartStop(SweepAcqAcqStartStop),
    .SCTestDone(SCTestDone), .SweepAcqDone(SweepAcqDone), .SweepAcqSingleDacDone(SweepAcqSingleDacDone),
    .dataIf(dataIf),
    .OutDac(OutDac), .OutChannelMask(OutChannelMask), .OutCTestChannel(OutCTestChannel),
    .OutSCParameterLoad(OutSCParameterLoad), .OutSCOrReadreg(OutSCOrReadreg),
    .OutSCTestStartStop(OutSCTestStartStop), .OutSweepAcqStartStop(OutSweepAcqStartStop),
    .OutUsbStartStop(OutUsbStartStop), .AcqStartStop(AcqStartStop), .SweepTestDone(SweepTestDone),
    .OutForceReset(OutForceReset), .ActiveMode(ActiveMode), .ModeSwitchBusy(ModeSwitchBusy),
    .ModeSwitchDone(ModeSwitchDone), .ModeSwitchTimeout(ModeSwitchTimeout)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [29:0] usbDac;
    logic [9:0]  scDac;
    logic [9:0]  swDac;
    logic [1:0]  sel;
    logic [3:0]  starts;   // {UsbAcq, UsbSweepTest, SweepTestUsb, SweepAcqAcq}
    logic [2:0]  status;   // {SCTestDone, SweepAcqDone, SweepAcqSingleDacDone}
    logic [29:0] expDac;
    logic [5:0]  expOut;   // {SCTestSS, SweepAcqSS, UsbSS, AcqSS, TestDone, ForceReset}
  } vec_t;

  vec_t vecs[8];
  int total = 0;
  int bad = 0;
  logic [1:0] curMode;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doSwitch(input logic [1:0] m);
    bit seen;
    seen = 1'b0;
    ModeSelect = m;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      if (ModeSwitchDone) seen = 1'b1;
    end
    check("switchDone", 256'(seen), 256'(1));
    check("switchMode", 256'(ActiveMode), 256'(m));
    curMode = m;
  endtask

  initial begin
    int forceAt, forceCnt, doneAt, toAt, toCnt;
    bit leak, seen;

    vecs[0] = '{2'b00, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd1, 4'b1000, 3'b111, {10'h003,10'h002,10'h001}, 6'b001100};
    vecs[1] = '{2'b00, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd1, 4'b0111, 3'b111, {10'h003,10'h002,10'h001}, 6'b000000};
    vecs[2] = '{2'b01, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd1, 4'b0110, 3'b100, {10'h155,10'h155,10'h155}, 6'b101010};
    vecs[3] = '{2'b01, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd1, 4'b1001, 3'b011, {10'h155,10'h155,10'h155}, 6'b000000};
    vecs[4] = '{2'b10, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd1, 4'b0101, 3'b011, {10'h003,10'h2AA,10'h001}, 6'b010111};
    vecs[5] = '{2'b10, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd3, 4'b0010, 3'b100, {10'h003,10'h002,10'h001}, 6'b001000};
    vecs[6] = '{2'b10, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd0, 4'b0000, 3'b000, {10'h003,10'h002,10'h2AA}, 6'b000000};
    vecs[7] = '{2'b10, {10'h003,10'h002,10'h001}, 10'h155, 10'h2AA, 2'd2, 4'b0000, 3'b000, {10'h2AA,10'h002,10'h001}, 6'b000000};

    ModeSelect = 2'b00; curMode = 2'b00;
    UsbDac = 30'h0; SCTestDac = 10'h0; SweepAcqDac = 10'h0; SweepAcqDacSelect = 2'd0;
    UsbChannelMask = {3{64'h0123_4567_89AB_CDEF}};
    SCTestChannelMask = {3{64'hFEDC_BA98_7654_3210}};
    UsbCTestChannel = 64'hAAAA_0000_AAAA_0001;
    SCTestCTestChannel = 64'h5555_0000_5555_0002;
    UsbSCParameterLoad = 0; SCTestSCParameterLoad = 0; SweepAcqSCParameterLoad = 0; UsbSCOrReadreg = 0;
    UsbAcqStartStop = 0; UsbSweepTestStartStop = 0; SweepTestUsbStartStop = 0; SweepAcqAcqStartStop = 0;
    SCTestDone = 0; SweepAcqDone = 0; SweepAcqSingleDacDone = 0;
    dataIf.AcqData = 16'h0; dataIf.AcqData_en = 0;
    dataIf.SweepAcqData = 16'h0; dataIf.SweepAcqData_en = 0;
    dataIf.SCTestData = 16'h0; dataIf.SCTestData_en = 0;

    // Reset state
    #12;
    check("rstDac", 256'(OutDac), 256'(0));
    check("rstMask", 256'(OutChannelMask), 256'(0));
    check("rstMode", 256'(ActiveMode), 256'(0));
    check("rstBusy", 256'(ModeSwitchBusy), 256'(0));
    check("rstFifoEn", 256'(dataIf.UsbFifoData_en), 256'(0));
    reset_n = 1'b1;
    tick();

    // ACQ data path
    dataIf.AcqData = 16'h1234; dataIf.AcqData_en = 1'b1;
    tick();
    check("acqFifoData", 256'(dataIf.UsbFifoData), 256'(16'h1234));
    check("acqFifoEn", 256'(dataIf.UsbFifoData_en), 256'(1));
    check("acqParEn", 256'(dataIf.ParallelData_en), 256'(0));
    dataIf.AcqData_en = 1'b0;
    tick();
    check("acqFifoEnOff", 256'(dataIf.UsbFifoData_en), 256'(0));

    // Mode 11 aliases ACQ and must not start a switch
    ModeSelect = 2'b11;
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ModeSwitchBusy) leak = 1'b1;
    end
    check("mode11NoBusy", 256'(leak), 256'(0));
    check("mode11Active", 256'(ActiveMode), 256'(0));
    ModeSelect = 2'b00;

    // Routing table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].mode != curMode) doSwitch(vecs[i].mode);
      ModeSelect = vecs[i].mode;
      UsbDac = vecs[i].usbDac; SCTestDac = vecs[i].scDac; SweepAcqDac = vecs[i].swDac;
      SweepAcqDacSelect = vecs[i].sel;
      {UsbAcqStartStop, UsbSweepTestStartStop, SweepTestUsbStartStop, SweepAcqAcqStartStop} = vecs[i].starts;
      {SCTestDone, SweepAcqDone, SweepAcqSingleDacDone} = vecs[i].status;
      tick();
      check($sformatf("vec%0d_dac", i), 256'(OutDac), 256'(vecs[i].expDac));
      check($sformatf("vec%0d_ctl", i),
            256'({OutSCTestStartStop, OutSweepAcqStartStop, OutUsbStartStop, AcqStartStop, SweepTestDone, OutForceReset}),
            256'(vecs[i].expOut));
      check($sformatf("vec%0d_mask", i), 256'(OutChannelMask),
            256'((vecs[i].mode == 2'b01) ? SCTestChannelMask : UsbChannelMask));
      check($sformatf("vec%0d_ctest", i), 256'(OutCTestChannel),
            256'((vecs[i].mode == 2'b01) ? SCTestCTestChannel : UsbCTestChannel));
    end
    UsbSweepTestStartStop = 0; SweepTestUsbStartStop = 0; SweepAcqAcqStartStop = 0;
    SCTestDone = 0; SweepAcqDone = 0; SweepAcqSingleDacDone = 0;

    // 00 -> 01 with ACQ data pulsing every 3 cycles for 20 cycles
    doSwitch(2'b00);
    UsbAcqStartStop = 1'b1;
    tick();
    check("acqStartRun", 256'(AcqStartStop), 256'(1));
    ModeSelect = 2'b01;
    tick();
    check("acqStartDrain", 256'(AcqStartStop), 256'(0));
    check("busyRise", 256'(ModeSwitchBusy), 256'(1));
    forceAt = 0; forceCnt = 0; doneAt = 0; leak = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      dataIf.AcqData_en = (t < 20) && (t % 3 == 0);
      tick();
      if (t == 3) check("drainFifoEn", 256'(dataIf.UsbFifoData_en), 256'(1));
      if (t == 26) check("drainHoldMode", 256'(ActiveMode), 256'(0));
      if (OutForceReset) begin
        forceCnt++;
        if (forceAt == 0) forceAt = t;
      end
      if (ModeSwitchDone && doneAt == 0) doneAt = t;
      if (AcqStartStop) leak = 1'b1;
    end
    check("quietForceAt", 256'(forceAt), 256'(27));
    check("quietForceCnt", 256'(forceCnt), 256'(1));
    check("quietDoneAt", 256'(doneAt), 256'(31));
    check("quietMode", 256'(ActiveMode), 256'(1));
    check("quietNoStart", 256'(leak), 256'(0));
    curMode = 2'b01;

    // 01 -> 10 with SCTest data stuck high: drain timeout
    dataIf.SCTestData_en = 1'b1;
    dataIf.SweepAcqData_en = 1'b1;
    ModeSelect = 2'b10;
    tick();
    toAt = 0; toCnt = 0; forceAt = 0; doneAt = 0;
    for (int t = 1; t <= 1035; t++) begin
      tick();
      if (ModeSwitchTimeout) begin
        toCnt++;
        if (toAt == 0) toAt = t;
      end
      if (OutForceReset && forceAt == 0) forceAt = t;
      if (ModeSwitchDone && doneAt == 0) doneAt = t;
      if (t == 1024) check("toMode", 256'(ActiveMode), 256'(2));
      if (t == 1025) check("settleFifoEn", 256'(dataIf.UsbFifoData_en), 256'(0));
      if (t == 1029) check("runFifoEn", 256'(dataIf.UsbFifoData_en), 256'(1));
    end
    check("toAt", 256'(toAt), 256'(1024));
    check("toCnt", 256'(toCnt), 256'(1));
    check("toForceAt", 256'(forceAt), 256'(1024));
    check("toDoneAt", 256'(doneAt), 256'(1028));
    dataIf.SCTestData_en = 1'b0;
    dataIf.SweepAcqData_en = 1'b0;
    curMode = 2'b10;

    // 00 -> 10 aborted after 3 drain cycles
    doSwitch(2'b00);
    ModeSelect = 2'b10;
    tick();
    for (int t = 1; t <= 3; t++) tick();
    check("abortBusy", 256'(ModeSwitchBusy), 256'(1));
    check("abortStartHeld", 256'(AcqStartStop), 256'(0));
    ModeSelect = 2'b00;
    seen = 1'b0; leak = 1'b0;
    for (int t = 4; t <= 15; t++) begin
      tick();
      if (OutForceReset) seen = 1'b1;
      if (ModeSwitchDone) leak = 1'b1;
      if (t == 4) check("abortBusyOff", 256'(ModeSwitchBusy), 256'(0));
      if (t == 5) check("abortStartBack", 256'(AcqStartStop), 256'(1));
    end
    check("abortNoForce", 256'(seen), 256'(0));
    check("abortNoDone", 256'(leak), 256'(0));
    check("abortMode", 256'(ActiveMode), 256'(0));

    // Reset asserted in the middle of SETTLE
    ModeSelect = 2'b01;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      tick();
      if (OutForceReset) seen = 1'b1;
    end
    check("settleReached", 256'(seen), 256'(1));
    tick();
    check("settleBusy", 256'(ModeSwitchBusy), 256'(1));
    #2 reset_n = 1'b0;
    #1;
    check("midRstDac", 256'(OutDac), 256'(0));
    check("midRstMask", 256'(OutChannelMask), 256'(0));
    check("midRstCTest", 256'(OutCTestChannel), 256'(0));
    check("midRstBusy", 256'(ModeSwitchBusy), 256'(0));
    check("midRstMode", 256'(ActiveMode), 256'(0));
    ModeSelect = 2'b00;
    #3 reset_n = 1'b1;
    tick();
    tick();
    check("postRstMode", 256'(ActiveMode), 256'(0));
    check("postRstBusy", 256'(ModeSwitchBusy), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
